// File: rtl/line_win_buf_if.sv
// Pixel type package and valid/ready stream interface used by line_win_buf.
package pixel_pkg;
  typedef struct packed {
    logic [7:0] red;
    logic [7:0] grn;
    logic [7:0] blu;
  } pixel_t;
endpackage

interface axis_if #(
  parameter int W = 24
);
  logic         vld;
  logic         rdy;
  logic [W-1:0] data;
  logic         ok;

  assign ok = vld & rdy;

  modport master (
    output vld,
    output data,
    input  rdy
  );

  modport slave (
    input  vld,
    input  data,
    input  ok,
    output rdy
  );
endinterface

// File: rtl/line_win_buf.sv
// Raster line buffer emitting WIN x WIN pixel windows through a FIFO with backpressure.
// Define LINE_WIN_BUF_ERR_EN to add the sticky line-length error output err.
module line_win_buf
  import pixel_pkg::*;
#(
  parameter int WIN        = 3,
  parameter int LINE_MAX   = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line,
  input  logic       done,
  axis_if.slave      axis_i,
  axis_if.master     axis_o
`ifdef LINE_WIN_BUF_ERR_EN
  ,
  output logic [1:0] err
`endif
);
  localparam int AW = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int NW = $clog2(WIN + 1);
  localparam int LW = $clog2(WIN);

  typedef pixel_t [WIN-1:0] col_t;
  typedef pixel_t [WIN-1:0][WIN-1:0] win_t;
  typedef enum logic {FILL, RUN} state_e;

  state_e         state_q;
  logic [WIN-1:0] sel_q;
  logic [WIN-1:0] sel1_q;
  logic [AW-1:0]  waddr_q;
  logic [LW-1:0]  filled_q;
  logic [NW-1:0]  col_cnt_q;
  logic           v1_q;
  logic           psh1_q;
  logic           push_q;
  pixel_t         p1_q;
  pixel_t         rdata [WIN];
  col_t           col;
  win_t           win_q;
  logic           acc;
  logic           rd;

  assign acc = axis_i.ok;
  assign rd  = acc && (state_q == RUN);

  for (genvar k = 0; k < WIN; k++) begin : g_ram
    pixel_t mem [LINE_MAX];
    pixel_t rd_q;
    always_ff @(posedge clk) begin
      if (acc && sel_q[k]) mem[waddr_q] <= axis_i.data;
      if (rd && !sel_q[k]) rd_q <= mem[waddr_q];
    end
    assign rdata[k] = rd_q;
  end

  // Oldest stored line sits in the RAM just after the one being written.
  always_comb begin
    col = '0;
    for (int k = 0; k < WIN; k++)
      if (sel1_q[k])
        for (int r = 0; r < WIN-1; r++)
          col[r] = rdata[(k + 1 + r) % WIN];
    col[WIN-1] = p1_q;
  end

  always_ff @(posedge clk) begin
    if (rst || done) begin
      state_q   <= FILL;
      filled_q  <= '0;
      sel_q     <= WIN'(1);
      waddr_q   <= '0;
      col_cnt_q <= '0;
    end else if (line) begin
      waddr_q   <= '0;
      col_cnt_q <= '0;
      sel_q     <= {sel_q[WIN-2:0], sel_q[WIN-1]};
      if (filled_q != LW'(WIN-1)) filled_q <= filled_q + 1'b1;
      if (filled_q == LW'(WIN-2)) state_q <= RUN;
    end else if (acc) begin
      waddr_q <= (waddr_q == AW'(LINE_MAX-1)) ? '0 : waddr_q + 1'b1;
      if (rd && col_cnt_q != NW'(WIN)) col_cnt_q <= col_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      push_q <= 1'b0;
    end else begin
      v1_q   <= rd;
      push_q <= v1_q && psh1_q;
    end
  end

  // Push decision is taken at accept so a line/done pulse cannot cancel it.
  always_ff @(posedge clk) begin
    if (rd) begin
      p1_q   <= axis_i.data;
      sel1_q <= sel_q;
      psh1_q <= (col_cnt_q >= NW'(WIN-1));
    end
    if (v1_q)
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN-1; c++)
          win_q[r][c] <= win_q[r][c+1];
        win_q[r][WIN-1] <= col[r];
      end
  end

  win_t          fmem [FIFO_DEPTH];
  logic [FW-1:0] wp_q;
  logic [FW-1:0] rp_q;
  logic [CW-1:0] cnt_q;
  logic          ovld_q;
  win_t          odata_q;
  logic          pop;

  assign pop = (cnt_q != '0) && (!ovld_q || axis_o.rdy);

  always_ff @(posedge clk) begin
    if (push_q) fmem[wp_q] <= win_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovld_q  <= 1'b0;
      odata_q <= '0;
    end else begin
      if (push_q)
        wp_q <= (wp_q == FW'(FIFO_DEPTH-1)) ? '0 : wp_q + 1'b1;
      if (pop)
        rp_q <= (rp_q == FW'(FIFO_DEPTH-1)) ? '0 : rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_q) - CW'(pop);
      if (pop) begin
        ovld_q  <= 1'b1;
        odata_q <= fmem[rp_q];
      end else if (axis_o.rdy) begin
        ovld_q <= 1'b0;
      end
    end
  end

  // Leaves room for the up to three columns already in flight.
  assign axis_i.rdy  = (cnt_q <= CW'(FIFO_DEPTH-3));
  assign axis_o.vld  = ovld_q;
  assign axis_o.data = odata_q;

`ifdef LINE_WIN_BUF_ERR_EN
  localparam int EW = $clog2(LINE_MAX + 2);

  logic [EW-1:0] len_q;
  logic [EW-1:0] len_d;
  logic [EW-1:0] ref_q;
  logic          have_ref_q;
  logic [1:0]    err_q;

  always_comb begin
    len_d = len_q;
    if (acc && len_q <= EW'(LINE_MAX)) len_d = len_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      ref_q      <= '0;
      have_ref_q <= 1'b0;
      err_q      <= '0;
    end else begin
      if (len_d > EW'(LINE_MAX)) err_q[0] <= 1'b1;
      if (done) begin
        len_q      <= '0;
        have_ref_q <= 1'b0;
      end else if (line) begin
        len_q <= '0;
        if (!have_ref_q) begin
          ref_q      <= len_d;
          have_ref_q <= 1'b1;
        end else if (len_d != ref_q) begin
          err_q[1] <= 1'b1;
        end
      end else begin
        len_q <= len_d;
      end
    end
  end

  assign err = err_q;
`endif
endmodule
